// File: rtl/nyq_interp_if.sv
// Bundle of the nyq_interp coefficient-write port and sample stream signals.
// master = driving side (source/controller), slave = the interpolator.
interface nyq_interp_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int MEM_WIDTH  = 24,
  parameter int IN_WIDTH   = 24,
  parameter int OUT_WIDTH  = 24
);
  logic                        WrEn_SI;
  logic [ADDR_WIDTH-1:0]       Addr_DI;
  logic signed [MEM_WIDTH-1:0] PAR_In_DI;
  logic signed [IN_WIDTH-1:0]  NYQI_In_DI;
  logic                        NYQI_InValid_SI;
  logic                        NYQI_InReady_SO;
  logic signed [OUT_WIDTH-1:0] NYQI_Out_DO;
  logic                        NYQI_Valid_DO;

  modport master (
    output WrEn_SI, Addr_DI, PAR_In_DI, NYQI_In_DI, NYQI_InValid_SI,
    input  NYQI_InReady_SO, NYQI_Out_DO, NYQI_Valid_DO
  );

  modport slave (
    input  WrEn_SI, Addr_DI, PAR_In_DI, NYQI_In_DI, NYQI_InValid_SI,
    output NYQI_InReady_SO, NYQI_Out_DO, NYQI_Valid_DO
  );
endinterface

// File: rtl/nyq_interp.sv
// Transmit-side x8 Nyquist interpolator: 32-tap polyphase FIR (8 phases x 4 taps),
// one input per 8-cycle frame, one saturated Q1.23 output per clock.
module nyq_interp #(
  parameter int ADDR_WIDTH = 5,
  parameter int MEM_WIDTH  = 24,
  parameter int IN_WIDTH   = 24,
  parameter int OUT_WIDTH  = 24,
  parameter int COEF_FRAC  = 23
) (
  input logic         Clk_CI,
  input logic         Rst_RBI,
  nyq_interp_if.slave bus
);
  localparam int NTAP   = 4;
  localparam int NCOEF  = 2 ** ADDR_WIDTH;
  localparam int PROD_W = MEM_WIDTH + IN_WIDTH;
  localparam int ACC_W  = PROD_W + 2;
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((64'sd1 <<< (OUT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = -OUT_MAX - 1;

  typedef enum logic {IDLE, RUN} state_e;

  state_e                      state_q;
  logic [2:0]                  phase_q;
  logic signed [IN_WIDTH-1:0]  x_q [NTAP];
  logic signed [MEM_WIDTH-1:0] coef_q [NCOEF];
  logic signed [OUT_WIDTH-1:0] out_q;
  logic                        vld_q;

  logic signed [PROD_W-1:0]    prod [NTAP];
  logic signed [ACC_W-1:0]     acc_d;
  logic signed [OUT_WIDTH-1:0] out_d;
  logic                        xfer;

  function automatic logic signed [OUT_WIDTH-1:0] shift_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> COEF_FRAC;
    if (s > OUT_MAX)      s = OUT_MAX;
    else if (s < OUT_MIN) s = OUT_MIN;
    return s[OUT_WIDTH-1:0];
  endfunction

  assign bus.NYQI_InReady_SO = (state_q == IDLE) || (state_q == RUN && phase_q == 3'd7);
  assign xfer                = bus.NYQI_InValid_SI && bus.NYQI_InReady_SO;
  assign bus.NYQI_Out_DO     = out_q;
  assign bus.NYQI_Valid_DO   = vld_q;

  // Phase p uses taps h[p], h[p+8], h[p+16], h[p+24] against x0..x3 (x0 newest).
  always_comb begin
    acc_d = '0;
    for (int k = 0; k < NTAP; k++) begin
      prod[k] = PROD_W'(coef_q[{k[1:0], phase_q}]) * PROD_W'(x_q[k]);
      acc_d   = acc_d + ACC_W'(prod[k]);
    end
  end

  assign out_d = shift_sat(acc_d);

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      for (int i = 0; i < NCOEF; i++) coef_q[i] <= '0;
    end else if (bus.WrEn_SI) begin
      coef_q[bus.Addr_DI] <= bus.PAR_In_DI;
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q <= IDLE;
      phase_q <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      for (int k = 0; k < NTAP; k++) x_q[k] <= '0;
    end else begin
      if (xfer) begin
        x_q[0] <= bus.NYQI_In_DI;
        for (int k = 1; k < NTAP; k++) x_q[k] <= x_q[k-1];
      end
      case (state_q)
        IDLE: begin
          vld_q <= 1'b0;
          if (xfer) begin
            phase_q <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          // Phase wraps 7 -> 0 naturally, which starts the next frame on a transfer.
          out_q   <= out_d;
          vld_q   <= 1'b1;
          phase_q <= phase_q + 3'd1;
          if (phase_q == 3'd7 && !xfer) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nyq_interp.sv
// Randomised self-checking bench for nyq_interp against a queue-based behavioural model.
module tb_nyq_interp;
  logic Clk_CI  = 1'b0;
  logic Rst_RBI = 1'b0;

  nyq_interp_if bus ();

  nyq_interp dut (
    .Clk_CI (Clk_CI),
    .Rst_RBI(Rst_RBI),
    .bus    (bus.slave)
  );

  always #5 Clk_CI = ~Clk_CI;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: coefficient table, sample history (index 0 newest),
  // queue of phases still owed for accepted samples, and the output register.
  longint m_h [32];
  longint m_x [4];
  int     m_pend [$];
  longint m_out;
  bit     m_vld;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic longint m_y(input int p);
    longint acc;
    acc = 0;
    for (int k = 0; k < 4; k++) acc += m_h[p + 8 * k] * m_x[k];
    acc = acc >>> 23;
    if (acc > 64'sd8388607)  acc = 64'sd8388607;
    if (acc < -64'sd8388608) acc = -64'sd8388608;
    return acc;
  endfunction

  task automatic m_reset();
    foreach (m_h[i]) m_h[i] = 0;
    foreach (m_x[i]) m_x[i] = 0;
    m_pend.delete();
    m_out = 0;
    m_vld = 0;
  endtask

  // One clock: check ready before the edge, advance the model, check outputs after it.
  task automatic step();
    bit     rdy, take, we;
    longint din, wd;
    int     wa, p;
    rdy  = (m_pend.size() <= 1);
    chk("ready", bus.NYQI_InReady_SO, rdy);
    take = bus.NYQI_InValid_SI && rdy;
    din  = longint'($signed(bus.NYQI_In_DI));
    we   = bus.WrEn_SI;
    wa   = int'(bus.Addr_DI);
    wd   = longint'($signed(bus.PAR_In_DI));
    @(posedge Clk_CI);
    if (m_pend.size() > 0) begin
      p     = m_pend.pop_front();
      m_out = m_y(p);
      m_vld = 1;
    end else begin
      m_vld = 0;
    end
    if (take) begin
      for (int k = 3; k > 0; k--) m_x[k] = m_x[k-1];
      m_x[0] = din;
      for (int i = 0; i < 8; i++) m_pend.push_back(i);
    end
    if (we) m_h[wa] = wd;
    #1;
    chk("valid", bus.NYQI_Valid_DO, m_vld);
    chk("out", $signed(bus.NYQI_Out_DO), m_out);
  endtask

  task automatic wr_step(input int a, input logic [23:0] d);
    bus.WrEn_SI   = 1'b1;
    bus.Addr_DI   = 5'(a);
    bus.PAR_In_DI = d;
    step();
    bus.WrEn_SI   = 1'b0;
  endtask

  task automatic send(input logic [23:0] d, input int n);
    bus.NYQI_InValid_SI = 1'b1;
    bus.NYQI_In_DI      = d;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic idle(input int n);
    bus.NYQI_InValid_SI = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bus.WrEn_SI         = 1'b0;
    bus.Addr_DI         = '0;
    bus.PAR_In_DI       = '0;
    bus.NYQI_In_DI      = '0;
    bus.NYQI_InValid_SI = 1'b0;
    m_reset();
    repeat (3) @(posedge Clk_CI);
    @(negedge Clk_CI);
    chk("rst_out", $signed(bus.NYQI_Out_DO), 0);
    chk("rst_valid", bus.NYQI_Valid_DO, 0);
    chk("rst_ready", bus.NYQI_InReady_SO, 1);
    Rst_RBI = 1'b1;
    @(posedge Clk_CI);
    #1;

    // Impulse: h[j]=j<<16, input 0x400000 then zeros gives j<<15 on 32 consecutive outputs.
    for (int j = 0; j < 32; j++) wr_step(j, 24'(j << 16));
    send(24'h400000, 1);
    for (int j = 0; j < 32; j++) begin
      bus.NYQI_In_DI = '0;
      step();
      chk("impulse", $signed(bus.NYQI_Out_DO), longint'(j) <<< 15);
    end
    send(24'h000000, 10);

    // Underrun: single sample, then exactly 8 outputs and a return to idle with Out held.
    idle(12);
    send(24'h100000, 1);
    idle(14);
    chk("underrun_ready", bus.NYQI_InReady_SO, 1);
    chk("underrun_valid", bus.NYQI_Valid_DO, 0);
    send(24'h7A0000, 1);
    idle(10);

    // Live coefficient write landing on the phase-2 edge of a frame.
    send(24'($urandom), 1);
    idle(2);
    bus.NYQI_InValid_SI = 1'b0;
    wr_step(5, 24'h200000);
    idle(8);

    // Saturation at both rails.
    for (int j = 0; j < 32; j++) wr_step(j, 24'h7FFFFF);
    send(24'h7FFFFF, 40);
    chk("sat_pos", $signed(bus.NYQI_Out_DO), 64'sd8388607);
    send(24'h800000, 40);
    chk("sat_neg", $signed(bus.NYQI_Out_DO), -64'sd8388608);
    idle(10);

    // Random coefficients, back-pressured stream with changing data and live writes.
    for (int j = 0; j < 32; j++) wr_step(j, 24'($signed(20'($urandom))));
    bus.NYQI_InValid_SI = 1'b1;
    for (int i = 0; i < 120; i++) begin
      bus.NYQI_In_DI = 24'($urandom);
      bus.WrEn_SI    = ($urandom_range(0, 7) == 0);
      bus.Addr_DI    = 5'($urandom);
      bus.PAR_In_DI  = 24'($signed(21'($urandom)));
      step();
    end
    bus.WrEn_SI = 1'b0;
    for (int i = 0; i < 200; i++) begin
      bus.NYQI_InValid_SI = ($urandom_range(0, 3) != 0);
      bus.NYQI_In_DI      = 24'($urandom);
      step();
    end

    // Asynchronous reset mid-frame, then confirm all coefficients read as zero.
    send(24'h345678, 11);
    #2;
    Rst_RBI = 1'b0;
    #1;
    m_reset();
    chk("midrst_out", $signed(bus.NYQI_Out_DO), 0);
    chk("midrst_valid", bus.NYQI_Valid_DO, 0);
    chk("midrst_ready", bus.NYQI_InReady_SO, 1);
    bus.NYQI_InValid_SI = 1'b0;
    @(negedge Clk_CI);
    Rst_RBI = 1'b1;
    @(posedge Clk_CI);
    #1;
    send(24'h7FFFFF, 1);
    send(24'h400000, 1);
    send(24'h123456, 1);
    send(24'h654321, 1);
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
